pipelined_decode_controller: RTL and testbench
==============================================

Name: pipelined_decode_controller

Overview:
- Second-generation ID-stage control unit: decodes the instruction opcode into WB/MEM/EXE/branch control and registers the result into the ID/EXE pipeline register.
- Adds bubble insertion for load-use hazards, flush on taken branch, a configurable branch-resolution stall counter, and illegal-opcode detection.
- Sits between the IF/ID register and the EXE stage. Drives Fetch_Stall back to the PC and IF/ID register.

Parameters:
- OPCODE_W, 6, opcode field width; must be at least 6.
- EXE_CMD_W, 4, ALU command width; must be at least 4, upper bits zero-filled.
- BR_STALL_CYCLES, 1, stall cycles after an accepted BEZ/BNE; 0 disables the stall.
- JMP_STALLS, 0, 1 means JMP also triggers the branch stall.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Opcode  in  OPCODE_W  opcode from IF/ID.
- Instr_Valid  in  1  IF/ID holds a real instruction.
- Hazard_Stall  in  1  load-use hazard from the hazard unit.
- Flush  in  1  taken branch resolved; kill the instruction in ID.
- Fetch_Stall  out  1  combinational; hold PC and IF/ID.
- Out_Valid  out  1  registered; ID/EXE holds a real instruction.
- Is_Imm, WB_En, MEM_R_En, MEM_W_En  out  1 each  registered controls.
- EXE_Cmd  out  EXE_CMD_W  registered ALU command.
- BR_Type  out  2  registered; 00 none, 01 BEZ, 10 BNE, 11 JMP.
- Illegal_Op  out  1  registered one-cycle pulse.

Behaviour:
- Reset: synchronous on clk while rst=1.
  - All registered outputs go to 0; the FSM goes to RUN; the counter clears.
  - Reset mid-stall abandons the stall immediately.
- Bubble: all registered outputs 0. EXE_Cmd is never X.
- Latency: 1 cycle. A decode accepted at edge t appears on the outputs after edge t.
- Decode table, opcode -> EXE_Cmd:
  - ADD=1 -> 0000; SUB=3 -> 0010; AND=5 -> 0100; OR=6 -> 0101; NOR=7 -> 0110; XOR=8 -> 0111.
  - SLA=9 -> 1000; SLL=10 -> 1000; SRA=11 -> 1001; SRL=12 -> 1010.
  - ADDI=32 -> 0000; SUBI=33 -> 0010; LD=36 -> 0000; ST=37 -> 0000.
  - BEZ=40, BNE=41, JMP=42 -> 0000.
- Decode table, other controls:
  - Is_Imm=1 for opcodes 32-42.
  - WB_En=1 for ALU ops, ADDI, SUBI and LD.
  - MEM_R_En=1 only for LD; MEM_W_En=1 only for ST.
  - NOP=0: valid instruction with all controls 0; Out_Valid=1.
  - Any other opcode is illegal: the output is a bubble and Illegal_Op pulses for 1 cycle.
- FSM states: RUN and BR_WAIT. Each cycle applies the first matching priority item:
  1. rst.
  2. Flush: bubble next cycle; go to RUN; counter cleared; Fetch_Stall=0.
  3. BR_WAIT: bubble; Fetch_Stall=1.
     - Counter decrements each cycle.
     - On the cycle the counter equals 1, go to RUN; IF/ID is released the following cycle.
  4. RUN with Hazard_Stall=1 and Instr_Valid=1: bubble; Fetch_Stall=1; the opcode is held and re-decoded later.
  5. RUN with Instr_Valid=1: decode normally. BEZ/BNE (and JMP if JMP_STALLS=1) with BR_STALL_CYCLES>0 loads counter=BR_STALL_CYCLES and goes to BR_WAIT.
  6. RUN with Instr_Valid=0: bubble.
- Fetch_Stall = (state==BR_WAIT | (Hazard_Stall & Instr_Valid)) & ~Flush & ~rst.
- Counter width is $clog2(BR_STALL_CYCLES+1). It never wraps; decrement stops at 0.
- Simultaneous events:
  - Flush with Hazard_Stall or in BR_WAIT: Flush wins.
  - Hazard_Stall in BR_WAIT: ignored; the counter continues.
- Opcode bits above bit 5 that are non-zero make the opcode illegal.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - opcode localparams;
  - BR_Type codes;
  - EXE_Cmd codes;
  - the ctrl_t packed struct {Is_Imm, WB_En, MEM_R_En, MEM_W_En, EXE_Cmd, BR_Type}.
- One sub-module, opcode_decoder: purely combinational, Opcode -> ctrl_t plus an illegal flag. The top level holds the FSM, the counter and the output register.

Test Plan:
- Reset: rst=1 for 2 cycles with Opcode=36 and Instr_Valid=1 -> all outputs 0 and Fetch_Stall=0. After release, LD gives MEM_R_En=1, WB_En=1, Is_Imm=1, EXE_Cmd=0000 one cycle later.
- Branch stall, BR_STALL_CYCLES=2: BEZ at t0 -> BR_Type=01 after t0, then 2 bubble cycles with Fetch_Stall=1, then ADD=1 decodes to EXE_Cmd=0000 and WB_En=1.
- Hazard: SUB=3 with Hazard_Stall=1 for 3 cycles -> 3 bubbles with Fetch_Stall=1, then EXE_Cmd=0010 and WB_En=1 exactly once.
- Flush priority: Flush=1 during BR_WAIT and with Hazard_Stall=1 -> bubble next cycle, Fetch_Stall=0, state back to RUN (next ST gives MEM_W_En=1 immediately).
- Illegal and mode: Opcode=50 -> bubble and a 1-cycle Illegal_Op. With JMP_STALLS=1, JMP=42 -> BR_Type=11 then BR_STALL_CYCLES bubbles; with JMP_STALLS=0 there is no stall.
- Reset mid-stall: rst during BR_WAIT with counter=2 -> next cycle RUN with Fetch_Stall=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the ID-stage decode controller: opcodes, ALU commands,
// branch types and the packed control bundle carried into ID/EXE.
package pipeline_ctrl_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  localparam logic [3:0] EXE_ADD = 4'b0000;
  localparam logic [3:0] EXE_SUB = 4'b0010;
  localparam logic [3:0] EXE_AND = 4'b0100;
  localparam logic [3:0] EXE_OR  = 4'b0101;
  localparam logic [3:0] EXE_NOR = 4'b0110;
  localparam logic [3:0] EXE_XOR = 4'b0111;
  localparam logic [3:0] EXE_SHL = 4'b1000;
  localparam logic [3:0] EXE_SRA = 4'b1001;
  localparam logic [3:0] EXE_SRL = 4'b1010;

  typedef struct packed {
    logic       Is_Imm;
    logic       WB_En;
    logic       MEM_R_En;
    logic       MEM_W_En;
    logic [3:0] EXE_Cmd;
    logic [1:0] BR_Type;
  } ctrl_t;

  typedef enum logic {
    ST_RUN,
    ST_BR_WAIT
  } state_e;

endpackage

// File: rtl/pipelined_decode_controller_opcode_decoder.sv
// Purely combinational opcode decode into the control bundle plus an
// illegal-opcode flag; illegal opcodes decode to an all-zero bundle.
module opcode_decoder
  import pipeline_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                illegal
);

  logic upper_nz;

  if (OPCODE_W > 6) begin : g_upper
    assign upper_nz = |opcode[OPCODE_W-1:6];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    unique case (opcode[5:0])
      OP_NOP:  ;
      OP_ADD:  begin ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_ADD; end
      OP_SUB:  begin ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_SUB; end
      OP_AND:  begin ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_AND; end
      OP_OR:   begin ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_OR;  end
      OP_NOR:  begin ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_NOR; end
      OP_XOR:  begin ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_XOR; end
      OP_SLA,
      OP_SLL:  begin ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_SHL; end
      OP_SRA:  begin ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_SRA; end
      OP_SRL:  begin ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_SRL; end
      OP_ADDI: begin ctrl.Is_Imm = 1'b1; ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_ADD; end
      OP_SUBI: begin ctrl.Is_Imm = 1'b1; ctrl.WB_En = 1'b1; ctrl.EXE_Cmd = EXE_SUB; end
      OP_LD:   begin ctrl.Is_Imm = 1'b1; ctrl.WB_En = 1'b1; ctrl.MEM_R_En = 1'b1; end
      OP_ST:   begin ctrl.Is_Imm = 1'b1; ctrl.MEM_W_En = 1'b1; end
      OP_BEZ:  begin ctrl.Is_Imm = 1'b1; ctrl.BR_Type = BR_BEZ; end
      OP_BNE:  begin ctrl.Is_Imm = 1'b1; ctrl.BR_Type = BR_BNE; end
      OP_JMP:  begin ctrl.Is_Imm = 1'b1; ctrl.BR_Type = BR_JMP; end
      default: illegal = 1'b1;
    endcase
    if (upper_nz) begin
      ctrl    = '0;
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/pipelined_decode_controller.sv
// ID-stage control unit: decodes the opcode, inserts bubbles for load-use
// hazards, flushes and branch-resolution stalls, and registers into ID/EXE.
module pipelined_decode_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int OPCODE_W        = 6,
  parameter int EXE_CMD_W       = 4,
  parameter int BR_STALL_CYCLES = 1,
  parameter int JMP_STALLS      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODE_W-1:0]  Opcode,
  input  logic                 Instr_Valid,
  input  logic                 Hazard_Stall,
  input  logic                 Flush,
  output logic                 Fetch_Stall,
  output logic                 Out_Valid,
  output logic                 Is_Imm,
  output logic                 WB_En,
  output logic                 MEM_R_En,
  output logic                 MEM_W_En,
  output logic [EXE_CMD_W-1:0] EXE_Cmd,
  output logic [1:0]           BR_Type,
  output logic                 Illegal_Op
);

  localparam int CNT_W = (BR_STALL_CYCLES > 0) ? $clog2(BR_STALL_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BR_STALL_CYCLES);

  ctrl_t            dec_ctrl;
  logic             dec_illegal;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic             accept;
  logic             br_stalls;

  opcode_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
    .opcode  (Opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // An instruction leaves ID only in RUN, with no flush and no load-use hazard.
  assign accept    = !Flush && (state_q == ST_RUN) && Instr_Valid && !Hazard_Stall;
  assign br_stalls = (BR_STALL_CYCLES > 0) && !dec_illegal &&
                     ((dec_ctrl.BR_Type == BR_BEZ) || (dec_ctrl.BR_Type == BR_BNE) ||
                      ((dec_ctrl.BR_Type == BR_JMP) && (JMP_STALLS != 0)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (state_q == ST_BR_WAIT) begin
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
      if (cnt_q <= CNT_W'(1)) state_d = ST_RUN;
    end else if (accept && br_stalls) begin
      state_d = ST_BR_WAIT;
      cnt_d   = CNT_LOAD;
    end
  end

  always_comb begin
    Fetch_Stall = ((state_q == ST_BR_WAIT) || (Hazard_Stall && Instr_Valid)) && !Flush && !rst;
    out_valid_d = accept && !dec_illegal;
    ctrl_d      = out_valid_d ? dec_ctrl : '0;
    illegal_d   = accept && dec_illegal;
  end

  // NOTE: synchronous reset clears every output flop so a bubble never carries X into EXE.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
    end
  end

  assign Out_Valid  = out_valid_q;
  assign Is_Imm     = ctrl_q.Is_Imm;
  assign WB_En      = ctrl_q.WB_En;
  assign MEM_R_En   = ctrl_q.MEM_R_En;
  assign MEM_W_En   = ctrl_q.MEM_W_En;
  assign EXE_Cmd    = EXE_CMD_W'(ctrl_q.EXE_Cmd);
  assign BR_Type    = ctrl_q.BR_Type;
  assign Illegal_Op = illegal_q;

endmodule

// File: tb/tb_pipelined_decode_controller.sv
// Scoreboard bench: two controller configurations share one random stimulus
// stream and are checked every cycle against a cycle-window reference model.
module tb_pipelined_decode_controller;

  localparam int OW   = 8;
  localparam int EW   = 6;
  localparam int NCFG = 2;

  typedef struct packed {
    logic [NCFG-1:0]       fs;
    logic [NCFG-1:0][13:0] out;
  } rec_t;

  logic clk = 1'b0;
  logic rst, instr_valid, hazard_stall, flush;
  logic [OW-1:0] opcode;

  logic          fs   [NCFG];
  logic          ov   [NCFG];
  logic          ii   [NCFG];
  logic          wb   [NCFG];
  logic          mr   [NCFG];
  logic          mw   [NCFG];
  logic [EW-1:0] exe  [NCFG];
  logic [1:0]    br   [NCFG];
  logic          ill  [NCFG];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   block_end [NCFG];
  logic [13:0] out_m [NCFG];
  rec_t exp_q [$];

  always #5 clk = ~clk;

  pipelined_decode_controller #(.OPCODE_W(OW), .EXE_CMD_W(EW), .BR_STALL_CYCLES(2), .JMP_STALLS(1)) dut_a (
    .clk(clk), .rst(rst), .Opcode(opcode), .Instr_Valid(instr_valid),
    .Hazard_Stall(hazard_stall), .Flush(flush), .Fetch_Stall(fs[0]),
    .Out_Valid(ov[0]), .Is_Imm(ii[0]), .WB_En(wb[0]), .MEM_R_En(mr[0]),
    .MEM_W_En(mw[0]), .EXE_Cmd(exe[0]), .BR_Type(br[0]), .Illegal_Op(ill[0])
  );

  pipelined_decode_controller #(.OPCODE_W(OW), .EXE_CMD_W(EW), .BR_STALL_CYCLES(1), .JMP_STALLS(0)) dut_b (
    .clk(clk), .rst(rst), .Opcode(opcode), .Instr_Valid(instr_valid),
    .Hazard_Stall(hazard_stall), .Flush(flush), .Fetch_Stall(fs[1]),
    .Out_Valid(ov[1]), .Is_Imm(ii[1]), .WB_En(wb[1]), .MEM_R_En(mr[1]),
    .MEM_W_En(mw[1]), .EXE_Cmd(exe[1]), .BR_Type(br[1]), .Illegal_Op(ill[1])
  );

  function automatic int stall_n(int c);
    return (c == 0) ? 2 : 1;
  endfunction

  function automatic bit jmp_stalls(int c);
    return (c == 0);
  endfunction

  // Expected ID/EXE contents {valid, imm, wb, mr, mw, cmd[5:0], br[1:0], illegal}.
  function automatic logic [13:0] decode_ref(int op);
    int cmd   = 0;
    bit legal = 1'b1;
    bit imm, wbe, mre, mwe;
    int brt;
    case (op)
      1, 32, 36, 37, 0, 40, 41, 42: cmd = 0;
      3, 33: cmd = 2;
      5:  cmd = 4;
      6:  cmd = 5;
      7:  cmd = 6;
      8:  cmd = 7;
      9, 10: cmd = 8;
      11: cmd = 9;
      12: cmd = 10;
      default: legal = 1'b0;
    endcase
    if (!legal) return 14'd1;
    imm = (op >= 32);
    wbe = (op >= 1 && op <= 12) || op == 32 || op == 33 || op == 36;
    mre = (op == 36);
    mwe = (op == 37);
    brt = (op >= 40) ? op - 39 : 0;
    return {1'b1, imm, wbe, mre, mwe, 6'(cmd), 2'(brt), 1'b0};
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d at %0t: got %h, expected %h", name, c, $time, act, exp);
    end
  endtask

  // One ID cycle: drive inputs, record what both configurations must show, advance the model.
  task automatic step(input bit r, input int op, input bit v, input bit hz, input bit fl);
    rec_t rec;
    bit   blocked;
    bit   stall_br;
    rst = r; opcode = OW'(op); instr_valid = v; hazard_stall = hz; flush = fl;
    for (int c = 0; c < NCFG; c++) begin
      blocked    = (cyc <= block_end[c]);
      rec.fs[c]  = (blocked || (hz && v)) && !fl && !r;
      rec.out[c] = out_m[c];
      if (r || fl) begin
        out_m[c]     = '0;
        block_end[c] = -1;
      end else if (blocked || !v || hz) begin
        out_m[c] = '0;
      end else begin
        out_m[c] = decode_ref(op);
        stall_br = (op == 40) || (op == 41) || ((op == 42) && jmp_stalls(c));
        if (stall_br && stall_n(c) > 0) block_end[c] = cyc + stall_n(c);
      end
    end
    exp_q.push_back(rec);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        for (int c = 0; c < NCFG; c++) begin
          check("fetch_stall", c, 32'(fs[c]), 32'(r.fs[c]));
          check("id_exe", c, 32'({ov[c], ii[c], wb[c], mr[c], mw[c], exe[c], br[c], ill[c]}),
                32'(r.out[c]));
        end
      end
    end
  end

  initial begin : stimulus
    int op;
    rst = 1'b1; opcode = OW'(36); instr_valid = 1'b1; hazard_stall = 1'b0; flush = 1'b0;
    for (int c = 0; c < NCFG; c++) begin
      block_end[c] = -1;
      out_m[c]     = '0;
    end
    @(posedge clk);
    #1;
    cyc = 1;
    step(1, 36, 1, 0, 0);
    step(0, 36, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Branch stall, then the held ADD
    step(0, 40, 1, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Load-use hazard on SUB
    repeat (3) step(0, 3, 1, 1, 0);
    step(0, 3, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Flush inside BR_WAIT and against a hazard
    step(0, 41, 1, 0, 0);
    step(0, 37, 1, 0, 1);
    step(0, 37, 1, 0, 0);
    step(0, 3, 1, 1, 1);
    step(0, 37, 1, 0, 0);
    // Illegal opcodes, NOP, JMP mode
    step(0, 50, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 65, 1, 0, 0);
    step(0, 42, 1, 0, 0);
    repeat (3) step(0, 6, 1, 0, 0);
    // Reset while the branch counter is loaded
    step(0, 40, 1, 0, 0);
    step(1, 40, 1, 0, 0);
    step(0, 5, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 85) begin
        case ($urandom_range(17))
          0: op = 0;   1: op = 1;   2: op = 3;   3: op = 5;   4: op = 6;
          5: op = 7;   6: op = 8;   7: op = 9;   8: op = 10;  9: op = 11;
          10: op = 12; 11: op = 32; 12: op = 33; 13: op = 36; 14: op = 37;
          15: op = 40; 16: op = 41; default: op = 42;
        endcase
      end else begin
        op = int'($urandom_range(255));
      end
      step($urandom_range(99) < 2, op, $urandom_range(99) < 80,
           $urandom_range(99) < 20, $urandom_range(99) < 8);
    end
    step(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("queue_drain", 0, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
